// File: rtl/sample_capture_fifo.sv
// sample_capture_fifo
//   First-word fall-through FIFO that buffers the 8-bit samples from the
//   select/mux stage. It hands them to a downstream consumer over valid/ready
//   and flags any push attempted while full in a sticky overflow bit.
//
// Ports
//   clk, rst      rising-edge clock; synchronous active-high reset
//   in_valid      producer offers in_data this cycle
//   in_data       sample from mux stage
//   in_ready      buffer can accept (not full)
//   out_valid     out_data holds the head entry (not empty)
//   out_data      head entry, zero while empty
//   out_ready     consumer takes the head this cycle
//   count         entries stored, 0..DEPTH
//   almost_full   count >= AF_LVL
//   overflow      sticky: push attempted while full
//   clr_ovf       clears overflow at the next edge (a new overflow wins)
module sample_capture_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Flags come only from the occupancy register, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign push  = in_valid & ~full;
    assign pop   = out_ready & ~empty;

    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign count       = cnt;
    assign almost_full = (cnt >= CW'(AF_LVL));
    // Storage is not cleared by reset. Masking the head while empty gives a
    // known zero after reset and never exposes in_data on the output.
    assign out_data    = empty ? '0 : mem[rd_ptr];

    // Storage has no reset. A full buffer rejects the write, so a dropped
    // sample never reaches a slot that is still occupied.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A new overflow event takes priority over clr_ovf.
            if (in_valid && full) overflow <= 1'b1;
            else if (clr_ovf)     overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sample_capture_fifo.sv
module tb_sample_capture_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [3:0] count;
    logic       almost_full;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    sample_capture_fifo #(.WIDTH(8), .DEPTH(8), .AF_LVL(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count), .almost_full(almost_full),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Advance one edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        step(); step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        idle();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'((i + 1) * 8'h11);
            step();
            checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_almost_full at %0d got %b", i + 1, almost_full); end
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL full_head got %h exp 11", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 8'((i + 1) * 8'h11);
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL drain_data got %b/%h exp 1/%h", out_valid, out_data, exp); end
            step();
        end
        checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL drain_empty got %b/%0d exp 0/0", out_valid, count); end
        idle();
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'((i + 1) * 8'h11); step();
        end
        // Full: 0x99 is dropped even though the head pops this cycle.
        in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL ovf_count got %0d exp 7", count); end
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp = 8'((i + 2) * 8'h11);
            checks++; if (out_data !== exp) begin errors++; $display("FAIL ovf_drain got %h exp %h", out_data, exp); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_99 got out_valid %b data %h exp 0", out_valid, out_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        out_ready = 1'b0; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        // Clear and a new overflow in the same cycle: set wins.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1); step();
        end
        in_valid = 1'b1; in_data = 8'hEE; clr_ovf = 1'b1;
        step();
        checks++; if (overflow !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ovf_set_wins got %b/%0d exp 1/8", overflow, count); end
        idle();
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (overflow !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL ovf_reset got %b/%0d exp 0/0", overflow, count); end
    endtask

    task automatic test_wrap();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(i);
            step();
            checks++; if (count !== 4'd1 || out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++; $display("FAIL wrap_%0d got cnt %0d v %b d %h exp 1/1/%h", i, count, out_valid, out_data, 8'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end got %0d/%b exp 0/0", count, out_valid); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'hA2; exp_q[1] = 8'hA3; exp_q[2] = 8'hA4;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA1 + i); step();
        end
        in_valid = 1'b1; in_data = 8'hA4; out_ready = 1'b1;
        step();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", count); end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data !== exp_q[i]) begin errors++; $display("FAIL b2b_data got %h exp %h", out_data, exp_q[i]); end
            step();
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", count); end
        idle();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + i); step();
        end
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL mrst_pre got %0d exp 5", count); end
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hDD; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL mrst_clear got %0d/%b/%h exp 0/0/00", count, out_valid, out_data);
        end
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 4'd1 || out_data !== 8'h5A) begin errors++; $display("FAIL mrst_next got %0d/%h exp 1/5a", count, out_data); end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
